// File: rtl/adder_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adder_measure_sequencer
// Description : Runs one ring-oscillator delay measurement on the
//               instrumented adder. It drives the adder operands and gates
//               the ring for a programmed window over R runs. It accumulates
//               the synchronised chain_out rising edges into one saturating
//               count.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_measure_sequencer #(
    parameter int CNT_W       = 32,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_a,
    input  logic [31:0]      cfg_b,
    input  logic [7:0]       cfg_settle,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic [3:0]       cfg_runs,
    input  logic             chain_out,
    output logic [31:0]      adder_a,
    output logic [31:0]      adder_b,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // A synchroniser shorter than two flops is not metastability-safe
    localparam int c_SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // The phase timer must hold either a settle count or a window count
    localparam int c_TMR_W  = (WIN_W > 8) ? WIN_W : 8;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_RUN    = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_DRAIN_LD  = c_TMR_W'(2);
    localparam logic [WIN_W-1:0]   c_WIN_ONE   = WIN_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);

    logic [2:0]          r_state;
    logic [31:0]         r_adder_a;
    logic [31:0]         r_adder_b;
    logic                r_ring_en;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic [7:0]          r_settle;
    logic [WIN_W-1:0]    r_window;
    logic [3:0]          r_runs;
    logic [3:0]          r_run_idx;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_SYNC_N-1:0] r_sync;
    logic                r_edge_prev;

    logic                w_rise;
    logic                w_count_en;
    logic                w_count_full;
    logic                w_more_runs;
    logic [c_TMR_W-1:0]  w_settle_ld;
    logic [c_TMR_W-1:0]  w_window_ld;

    // Bring the asynchronous ring tap into the clock domain and keep one
    // extra flop of history for rising-edge detection
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_sync      <= '0;
            r_edge_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[c_SYNC_N-2:0], chain_out};
            r_edge_prev <= r_sync[c_SYNC_N-1];
        end
    end

    assign w_rise       = r_sync[c_SYNC_N-1] & ~r_edge_prev;
    // DRAIN is included so that edges still in the synchroniser are counted
    assign w_count_en   = w_rise && ((r_state == c_ST_RUN) || (r_state == c_ST_DRAIN));
    assign w_count_full = &r_count;
    assign w_more_runs  = ({1'b0, r_run_idx} + 5'd1) < {1'b0, r_runs};
    assign w_settle_ld  = c_TMR_W'(r_settle) - c_TMR_ONE;
    assign w_window_ld  = c_TMR_W'(r_window) - c_TMR_ONE;

    // Sequencer: latch configuration, time each phase, loop over runs and
    // accumulate edges; every output is a register updated on phase entry
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state    <= c_ST_IDLE;
            r_adder_a  <= '0;
            r_adder_b  <= '0;
            r_ring_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_settle   <= '0;
            r_window   <= '0;
            r_runs     <= '0;
            r_run_idx  <= '0;
            r_timer    <= '0;
        end else begin
            if (w_count_en) begin
                if (w_count_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + c_CNT_ONE;
                end
            end

            if (abort && r_busy) begin
                // The partial result stays visible; an edge arriving on the
                // abort cycle is dropped
                r_state    <= c_ST_IDLE;
                r_ring_en  <= 1'b0;
                r_busy     <= 1'b0;
                r_count    <= r_count;
                r_overflow <= r_overflow;
            end else begin
                case (r_state)
                    c_ST_IDLE, c_ST_DONE: begin
                        if (start) begin
                            // Operands appear on the adder during the LOAD cycle
                            r_state    <= c_ST_LOAD;
                            r_adder_a  <= cfg_a;
                            r_adder_b  <= cfg_b;
                            r_settle   <= cfg_settle;
                            r_window   <= (cfg_window == '0) ? c_WIN_ONE : cfg_window;
                            r_runs     <= (cfg_runs == 4'd0) ? 4'd1 : cfg_runs;
                            r_run_idx  <= 4'd0;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                            r_done     <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                    c_ST_LOAD: begin
                        if (r_settle != 8'd0) begin
                            r_state <= c_ST_SETTLE;
                            r_timer <= w_settle_ld;
                        end else begin
                            r_state   <= c_ST_RUN;
                            r_ring_en <= 1'b1;
                            r_timer   <= w_window_ld;
                        end
                    end
                    c_ST_SETTLE: begin
                        if (r_timer == '0) begin
                            r_state   <= c_ST_RUN;
                            r_ring_en <= 1'b1;
                            r_timer   <= w_window_ld;
                        end else begin
                            r_timer <= r_timer - c_TMR_ONE;
                        end
                    end
                    c_ST_RUN: begin
                        if (r_timer == '0) begin
                            r_state   <= c_ST_DRAIN;
                            r_ring_en <= 1'b0;
                            r_timer   <= c_DRAIN_LD;
                        end else begin
                            r_timer <= r_timer - c_TMR_ONE;
                        end
                    end
                    c_ST_DRAIN: begin
                        if (r_timer != '0) begin
                            r_timer <= r_timer - c_TMR_ONE;
                        end else if (w_more_runs) begin
                            r_run_idx <= r_run_idx + 4'd1;
                            if (r_settle != 8'd0) begin
                                r_state <= c_ST_SETTLE;
                                r_timer <= w_settle_ld;
                            end else begin
                                r_state   <= c_ST_RUN;
                                r_ring_en <= 1'b1;
                                r_timer   <= w_window_ld;
                            end
                        end else begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= c_ST_IDLE;
                        r_ring_en <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign adder_a  = r_adder_a;
    assign adder_b  = r_adder_b;
    assign ring_en  = r_ring_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adder_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_measure_sequencer
// Description : Self-checking bench for adder_measure_sequencer. Directed
//               measurements plus randomised ones are compared against a
//               schedule/edge model derived from the phase timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_measure_sequencer;

    localparam int CNT_W = 32;
    localparam int WIN_W = 16;
    localparam longint c_CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_n;
    logic             start;
    logic             abort;
    logic [31:0]      cfg_a;
    logic [31:0]      cfg_b;
    logic [7:0]       cfg_settle;
    logic [WIN_W-1:0] cfg_window;
    logic [3:0]       cfg_runs;
    logic             chain_out;
    logic [31:0]      adder_a;
    logic [31:0]      adder_b;
    logic             ring_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int osc_ph = 0;
    // 0 hold, 1 oscillator (toggle every 2 ring cycles), 2 random, 3 toggle each cycle
    int chain_mode = 0;
    bit hist [0:16383];

    adder_measure_sequencer #(
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .SYNC_STAGES(2)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n  (wb_rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .cfg_settle(cfg_settle),
        .cfg_window(cfg_window),
        .cfg_runs  (cfg_runs),
        .chain_out (chain_out),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .ring_en   (ring_en),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Cycle index: cycle n is the interval following the n-th rising edge
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then update the ring tap and log its value for the model
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
        if (chain_mode == 1) begin
            if (ring_en) begin
                osc_ph++;
                if (osc_ph % 2 == 0) chain_out = ~chain_out;
            end
        end else if (chain_mode == 2) begin
            chain_out = 1'($urandom_range(0, 1));
        end else if (chain_mode == 3) begin
            chain_out = ~chain_out;
        end
        if (cyc < 16384) hist[cyc] = chain_out;
    endtask

    // Ring is closed for the W cycles after S settle cycles of each run period
    function automatic bit exp_ring(int rel, int s, int w, int r);
        int p;
        int off;
        p = s + w + 3;
        if (rel < 2 || rel >= 2 + r * p) return 1'b0;
        off = (rel - 2) % p;
        return (off >= s) && (off < s + w);
    endfunction

    // A tap rise first present in cycle k is seen two synchroniser cycles
    // later; it counts if that cycle lies in a run window or its drain and
    // before the cut-off cycle lim
    function automatic longint exp_edges(int c0, int s, int w, int r, int lim);
        longint n;
        int b;
        n = 0;
        for (int ri = 0; ri < r; ri++) begin
            b = c0 + 2 + ri * (s + w + 3);
            for (int d = b + s; d <= b + s + w + 2; d++) begin
                if (d < lim && hist[d-2] && !hist[d-3]) n++;
            end
        end
        return n;
    endfunction

    task automatic measure(input logic [31:0] a, input logic [31:0] b,
                           input int s_cfg, input int w_cfg, input int r_cfg,
                           input int kill_at, input bit kill_rst,
                           input bit disturb, input bit saturate);
        int s;
        int w;
        int r;
        int c0;
        int rel;
        int done_rel;
        longint base;
        longint e;
        bit ov;
        s        = s_cfg;
        w        = (w_cfg == 0) ? 1 : w_cfg;
        r        = (r_cfg == 0) ? 1 : r_cfg;
        done_rel = 2 + r * (s + w + 3);
        base     = 0;
        cfg_a      = a;
        cfg_b      = b;
        cfg_settle = 8'(s_cfg);
        cfg_window = 16'(w_cfg);
        cfg_runs   = 4'(r_cfg);
        start      = 1'b1;
        c0         = cyc;
        osc_ph     = 0;
        tick();
        start = 1'b0;
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_adder_a", 64'(adder_a), 64'(a));
        chk("load_adder_b", 64'(adder_b), 64'(b));
        chk("load_count", 64'(count), 64'd0);
        chk("load_done", 64'(done), 64'd0);
        chk("load_ring", 64'(ring_en), 64'd0);
        for (int i = 0; i < done_rel - 1; i++) begin
            tick();
            rel = cyc - c0;
            if (kill_at >= 0 && rel == kill_at + 1) begin
                abort    = 1'b0;
                wb_rst_n = 1'b1;
                chk("kill_ring", 64'(ring_en), 64'd0);
                chk("kill_busy", 64'(busy), 64'd0);
                chk("kill_done", 64'(done), 64'd0);
                if (kill_rst) begin
                    chk("rst_count", 64'(count), 64'd0);
                    chk("rst_adder_a", 64'(adder_a), 64'd0);
                    chk("rst_overflow", 64'(overflow), 64'd0);
                end else begin
                    chk("abort_count", 64'(count), 64'(exp_edges(c0, s, w, r, c0 + kill_at)));
                    chk("abort_adder_a", 64'(adder_a), 64'(a));
                end
                return;
            end
            if (rel == done_rel) begin
                e  = base + exp_edges(c0, s, w, r, c0 + done_rel);
                ov = (e > c_CNT_MAX);
                if (ov) e = c_CNT_MAX;
                chk("done_flag", 64'(done), 64'd1);
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_ring", 64'(ring_en), 64'd0);
                chk("done_count", 64'(count), 64'(e));
                chk("done_overflow", 64'(overflow), 64'(ov));
                chk("done_adder_a", 64'(adder_a), 64'(a));
                chk("done_adder_b", 64'(adder_b), 64'(b));
            end else begin
                chk("ring_sched", 64'(ring_en), 64'(exp_ring(rel, s, w, r)));
                chk("busy_sched", 64'(busy), 64'd1);
                chk("done_early", 64'(done), 64'd0);
            end
            if (saturate && rel == 2 + s) begin
                force dut.r_count = 32'hFFFF_FFFE;
                #1;
                release dut.r_count;
                base = 64'hFFFF_FFFE;
            end
            if (disturb && rel == 3 + s) begin
                start      = 1'b1;
                cfg_a      = $urandom;
                cfg_b      = $urandom;
                cfg_settle = 8'($urandom);
                cfg_window = 16'($urandom);
                cfg_runs   = 4'($urandom);
            end else if (disturb && rel == 4 + s) begin
                start = 1'b0;
            end
            if (kill_at >= 0 && rel == kill_at) begin
                if (kill_rst) wb_rst_n = 1'b0;
                else abort = 1'b1;
            end
        end
    endtask

    initial begin
        int s;
        int w;
        int r;
        int dr;
        int k;
        wb_rst_n   = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        cfg_a      = '0;
        cfg_b      = '0;
        cfg_settle = '0;
        cfg_window = '0;
        cfg_runs   = '0;
        chain_out  = 1'b0;

        // Reset held two cycles with start high and the tap toggling
        chain_mode = 3;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ring", 64'(ring_en), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_outs", 64'({adder_a, adder_b} | 64'(count) | 64'(overflow)), 64'd0);
        end
        wb_rst_n   = 1'b1;
        start      = 1'b0;
        chain_mode = 0;
        chain_out  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Directed measurements with the oscillator model
        chain_mode = 1;
        measure(32'h0000_4000, 32'd1, 2, 16, 1, -1, 1'b0, 1'b0, 1'b0);
        chk("single_count", 64'(count), 64'd4);
        measure(32'h0000_4000, 32'd1, 2, 16, 3, -1, 1'b0, 1'b0, 1'b0);
        chk("multi_count", 64'(count), 64'd12);
        measure(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, -1, 1'b0, 1'b0, 1'b0);

        // Abort at cycle 10, idle through cycle 19, restart at cycle 20
        measure(32'h0000_4000, 32'd1, 2, 16, 1, 10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("idle_hold_a", 64'(adder_a), 64'h4000);
            chk("idle_busy2", 64'(busy), 64'd0);
            chk("idle_done2", 64'(done), 64'd0);
        end
        measure(32'h0000_4000, 32'd1, 2, 16, 1, -1, 1'b0, 1'b0, 1'b0);

        // Saturation, plus start/cfg disturbance during the run
        measure(32'h0000_4000, 32'd1, 2, 16, 1, -1, 1'b0, 1'b1, 1'b1);
        chk("sat_count", 64'(count), 64'hFFFF_FFFF);
        chk("sat_overflow", 64'(overflow), 64'd1);

        // Reset asserted mid-run
        measure(32'hCAFE_F00D, 32'h0BAD_BEEF, 1, 8, 2, 6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();

        // Randomised measurements with a random tap and occasional aborts
        chain_mode = 2;
        for (int t = 0; t < 16; t++) begin
            s  = $urandom_range(0, 5);
            w  = $urandom_range(0, 20);
            r  = $urandom_range(0, 3);
            dr = 2 + ((r == 0) ? 1 : r) * (s + ((w == 0) ? 1 : w) + 3);
            k  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dr - 2) : -1;
            measure($urandom, $urandom, s, w, r, k, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
